// File: rtl/booth_datapath.sv
`default_nettype none
// ============================================================================
// Module      : booth_datapath
// Description : Radix-2 Booth multiplier datapath (16x16 signed -> 32-bit),
//               driven cycle-by-cycle by the Booth control FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_datapath #(
  parameter int N = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       ctrl,
  input  logic [N-1:0]     multiplicand,
  input  logic [N-1:0]     multiplier,
  output logic [3:0]       cont,
  output logic [2*N-1:0]   product,
  output logic             done
);

  localparam logic [2:0] c_load = 3'b110;
  localparam logic [2:0] c_step = 3'b101;

  // One guard bit on A and M keeps -32768 and its negation representable.
  logic [N:0]     r_a;
  logic [N-1:0]   r_q;
  logic           r_q1;
  logic [N:0]     r_m;

  logic [N:0]     w_sum;
  logic [2*N+1:0] w_shifted;

  always_comb begin
    w_sum = r_a;
    case ({r_q[0], r_q1})
      2'b01:   w_sum = r_a + r_m;
      2'b10:   w_sum = r_a - r_m;
      default: w_sum = r_a;
    endcase
  end

  // Arithmetic right shift of {S, Q, q_1}; the old q_1 falls off the end.
  assign w_shifted = {w_sum[N], w_sum, r_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a     <= '0;
      r_q     <= '0;
      r_q1    <= 1'b0;
      r_m     <= '0;
      cont    <= '0;
      product <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (ctrl)
        c_load: begin
          r_a  <= '0;
          r_q  <= multiplier;
          r_q1 <= 1'b0;
          r_m  <= {multiplicand[N-1], multiplicand};
          cont <= '0;
        end
        c_step: begin
          r_a  <= w_shifted[2*N+1:N+1];
          r_q  <= w_shifted[N:1];
          r_q1 <= w_shifted[0];
          cont <= cont + 4'd1;
          if (cont == 4'd15) begin
            product <= w_shifted[2*N:1];
            done    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_booth_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_datapath
// Description : Directed self-checking bench for booth_datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_datapath;

  localparam logic [2:0] c_hold = 3'b000;
  localparam logic [2:0] c_load = 3'b110;
  localparam logic [2:0] c_step = 3'b101;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  ctrl;
  logic [15:0] multiplicand;
  logic [15:0] multiplier;
  logic [3:0]  cont;
  logic [31:0] product;
  logic        done;

  int tests_run = 0;
  int tests_failed = 0;
  int done_count = 0;

  booth_datapath #(.N(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .ctrl         (ctrl),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .cont         (cont),
    .product      (product),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one cycle with the given control word; count done pulses seen after the edge.
  task automatic cycle(input logic [2:0] c);
    @(negedge clk);
    ctrl = c;
    @(posedge clk);
    #1;
    if (done === 1'b1) done_count++;
  endtask

  task automatic load(input logic [15:0] m, input logic [15:0] q);
    @(negedge clk);
    ctrl = c_load;
    multiplicand = m;
    multiplier = q;
    @(posedge clk);
    #1;
    multiplicand = 16'hDEAD;
    multiplier = 16'hBEEF;
  endtask

  task automatic steps(input int n, input int first_cont, input bit chk_cont);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ctrl = c_step;
      if (chk_cont) check($sformatf("cont_step%0d", first_cont + i), {28'd0, cont}, (first_cont + i) & 15);
      @(posedge clk);
      #1;
      if (done === 1'b1) done_count++;
      if (first_cont + i < 15) check("done_early", {31'd0, done}, 32'd0);
    end
  endtask

  task automatic finish_checks(input string tag, input logic [31:0] exp);
    check({tag, "_product"}, product, exp);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_cont"}, {28'd0, cont}, 32'd0);
    cycle(c_hold);
    check({tag, "_done_drop"}, {31'd0, done}, 32'd0);
    check({tag, "_product_hold"}, product, exp);
  endtask

  task automatic run_mult(input string tag, input logic [15:0] m, input logic [15:0] q,
                          input logic [31:0] exp);
    load(m, q);
    steps(16, 0, 1'b1);
    finish_checks(tag, exp);
  endtask

  initial begin
    reset = 1'b1;
    ctrl = c_hold;
    multiplicand = '0;
    multiplier = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cont", {28'd0, cont}, 32'd0);
    check("rst_product", product, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_mult("3x5", 16'd3, 16'd5, 32'h0000000F);
    run_mult("m7x6", 16'hFFF9, 16'd6, 32'hFFFFFFD6);
    run_mult("minxmin", 16'h8000, 16'h8000, 32'h40000000);
    run_mult("maxxmin", 16'h7FFF, 16'h8000, 32'hC0008000);

    // Abort after 8 steps: only the reloaded run may produce a done pulse.
    done_count = 0;
    load(16'd3, 16'd5);
    steps(8, 0, 1'b0);
    load(16'd100, 16'hFFFE);
    check("abort_cont_reload", {28'd0, cont}, 32'd0);
    steps(16, 0, 1'b1);
    check("abort_product", product, 32'hFFFFFF38);
    cycle(c_hold);
    check("abort_done_count", done_count, 32'd1);

    // Interrupted stepping, including an undefined code acting as hold.
    done_count = 0;
    load(16'hFFF9, 16'd6);
    steps(5, 0, 1'b1);
    cycle(c_hold);
    cycle(3'b111);
    cycle(3'b100);
    cycle(c_hold);
    check("gap_cont", {28'd0, cont}, 32'd5);
    check("gap_done_count", done_count, 32'd0);
    steps(11, 5, 1'b1);
    check("gap_done_count_end", done_count, 32'd1);
    finish_checks("gap", 32'hFFFFFFD6);

    // Reset in the middle of a run clears everything.
    load(16'd1234, 16'd77);
    steps(7, 0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    ctrl = c_step;
    @(posedge clk);
    #1;
    check("midrst_cont", {28'd0, cont}, 32'd0);
    check("midrst_product", product, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    ctrl = c_hold;
    run_mult("post_rst", 16'd1234, 16'd77, 32'd95018);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
